// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage with load alignment and timeout
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        load_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_WRITE     = 2'd2
    } state_t;

    state_t         r_state;
    logic [4:0]     r_rd;
    logic           r_wen;
    logic [2:0]     r_funct3;
    logic [1:0]     r_off;
    logic [CW-1:0]  r_cnt;
    logic           r_dmem_req;
    logic [31:0]    r_dmem_addr;
    logic           r_rf_we;
    logic [4:0]     r_rf_rd;
    logic [31:0]    r_rf_wdata;
    logic           r_load_err;

    logic           w_transfer;
    logic           w_illegal;
    logic           w_alu_writes;
    logic           w_load_writes;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_data;

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign dmem_req  = r_dmem_req;
    assign dmem_addr = r_dmem_addr;
    assign rf_we     = r_rf_we;
    assign rf_rd     = r_rf_rd;
    assign rf_wdata  = r_rf_wdata;
    assign load_err  = r_load_err;

    assign w_transfer    = in_valid & in_ready;
    assign w_alu_writes  = in_wen & (in_rd != 5'd0);
    assign w_load_writes = r_wen & (r_rd != 5'd0);

    // Classify an incoming load as illegal: unknown funct3 or misaligned access
    always_comb begin
        w_illegal = 1'b0;
        case (in_funct3)
            F3_LB, F3_LBU: w_illegal = 1'b0;
            F3_LH, F3_LHU: w_illegal = in_result[0];
            F3_LW:         w_illegal = (in_result[1:0] != 2'b00);
            default:       w_illegal = 1'b1;
        endcase
    end

    // Pick the addressed byte/halfword of the returned word and extend it
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = dmem_rdata;
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  w_load_data = {24'h000000, w_byte};
            F3_LHU:  w_load_data = {16'h0000, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Stage FSM: accept, wait for memory, then write the register file for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rd        <= 5'd0;
            r_wen       <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_cnt       <= '0;
            r_dmem_req  <= 1'b0;
            r_dmem_addr <= 32'h0;
            r_rf_we     <= 1'b0;
            r_rf_rd     <= 5'd0;
            r_rf_wdata  <= 32'h0;
            r_load_err  <= 1'b0;
        end else begin
            r_rf_we    <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_transfer) begin
                        if (!in_is_load) begin
                            // ALU result goes straight to the write cycle
                            r_state <= ST_WRITE;
                            r_rf_we <= w_alu_writes;
                            if (w_alu_writes) begin
                                r_rf_rd    <= in_rd;
                                r_rf_wdata <= in_result;
                            end
                        end else if (w_illegal) begin
                            // Rejected load: flag it and stay ready, nothing reaches memory
                            r_load_err <= 1'b1;
                        end else begin
                            r_rd        <= in_rd;
                            r_wen       <= in_wen;
                            r_funct3    <= in_funct3;
                            r_off       <= in_result[1:0];
                            r_cnt       <= '0;
                            r_dmem_req  <= 1'b1;
                            r_dmem_addr <= {in_result[31:2], 2'b00};
                            r_state     <= ST_LOAD_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    // Ack is checked first so an ack on the last allowed cycle still completes
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= ST_WRITE;
                        r_rf_we    <= w_load_writes;
                        if (w_load_writes) begin
                            r_rf_rd    <= r_rd;
                            r_rf_wdata <= w_load_data;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_dmem_req <= 1'b0;
                        r_load_err <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;

    wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_result  (in_result),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned a;
        a = addr % 4;
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return a == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint unsigned sh, v;
        longint          s;
        sh = 64'(addr % 4) * 8;
        case (f3)
            3'd0, 3'd4: begin
                v = (64'(word) >> sh) % 256;
                s = (f3 == 3'd0 && v >= 128) ? longint'(v) - 256 : longint'(v);
            end
            3'd1, 3'd5: begin
                v = (64'(word) >> sh) % 65536;
                s = (f3 == 3'd1 && v >= 32768) ? longint'(v) - 65536 : longint'(v);
            end
            default: s = longint'(64'(word));
        endcase
        return s[31:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_hold_rd"}, 32'(rf_rd), 32'(exp_rd));
        chk({tag, "_hold_wdata"}, rf_wdata, exp_wdata);
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        bit writes;
        writes = wen && (rd != 5'd0);
        chk("alu_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_wen = wen;
        in_funct3 = 3'($urandom); in_result = res;
        step();
        in_valid = 1'b0;
        if (writes) begin
            exp_rd = rd;
            exp_wdata = res;
        end
        chk("alu_rf_we", 32'(rf_we), 32'(writes));
        chk("alu_ready_low", 32'(in_ready), 32'd0);
        check_hold("alu");
        step();
        chk("alu_ready_back", 32'(in_ready), 32'd1);
        chk("alu_rf_we_off", 32'(rf_we), 32'd0);
    endtask

    // ack_at: number of no-ack cycles before ack; >= TIMEOUT means memory never answers
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic wen, input int ack_at, input logic [31:0] word);
        bit writes;
        bit acked;
        int req_cycles;
        writes = wen && (rd != 5'd0);
        chk("ld_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_wen = wen;
        in_funct3 = f3; in_result = addr;
        step();
        in_valid = 1'b0;
        if (!ref_legal(f3, addr)) begin
            chk("bad_ld_err", 32'(load_err), 32'd1);
            chk("bad_ld_req", 32'(dmem_req), 32'd0);
            chk("bad_ld_we", 32'(rf_we), 32'd0);
            chk("bad_ld_ready", 32'(in_ready), 32'd1);
            step();
            chk("bad_ld_err_off", 32'(load_err), 32'd0);
            check_hold("bad_ld");
            return;
        end
        acked = 1'b0;
        req_cycles = 0;
        for (int c = 0; c < TIMEOUT; c++) begin
            chk("ld_req", 32'(dmem_req), 32'd1);
            chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("ld_we_wait", 32'(rf_we), 32'd0);
            req_cycles++;
            dmem_rdata = $urandom;
            if (c == ack_at) begin
                dmem_ack = 1'b1;
                dmem_rdata = word;
                acked = 1'b1;
            end
            step();
            dmem_ack = 1'b0;
            if (acked) break;
        end
        if (acked) begin
            if (writes) begin
                exp_rd = rd;
                exp_wdata = ref_load(f3, addr, word);
            end
            chk("ld_rf_we", 32'(rf_we), 32'(writes));
            chk("ld_req_drop", 32'(dmem_req), 32'd0);
            chk("ld_no_err", 32'(load_err), 32'd0);
            check_hold("ld");
            step();
            chk("ld_rf_we_off", 32'(rf_we), 32'd0);
            chk("ld_idle", 32'(busy), 32'd0);
        end else begin
            chk("to_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
            chk("to_err", 32'(load_err), 32'd1);
            chk("to_req_drop", 32'(dmem_req), 32'd0);
            chk("to_we", 32'(rf_we), 32'd0);
            chk("to_idle", 32'(busy), 32'd0);
            step();
            chk("to_err_off", 32'(load_err), 32'd0);
            check_hold("to");
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_wen = 1'b0; in_is_load = 1'b0;
        in_funct3 = 3'd0; in_result = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        exp_rd = 5'd0; exp_wdata = 32'h0;
        step(); step();
        reset = 1'b0;
        step();

        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_rd", 32'(rf_rd), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        do_alu(5'd5, 1'b1, 32'hDEADBEEF);
        chk("alu_rd5", 32'(rf_rd), 32'd5);
        chk("alu_data", rf_wdata, 32'hDEADBEEF);
        do_alu(5'd0, 1'b1, 32'h12345678);
        do_alu(5'd9, 1'b0, 32'hCAFEF00D);

        do_load(3'd0, 32'h0000_1003, 5'd7, 1'b1, 3, 32'h80FF_1234);
        chk("lb_val", rf_wdata, 32'hFFFFFF80);
        do_load(3'd4, 32'h0000_1003, 5'd7, 1'b1, 3, 32'h80FF_1234);
        chk("lbu_val", rf_wdata, 32'h00000080);
        do_load(3'd1, 32'h0000_2002, 5'd8, 1'b1, 0, 32'h8001_7FFF);
        chk("lh_val", rf_wdata, 32'hFFFF8001);
        do_load(3'd5, 32'h0000_2002, 5'd8, 1'b1, 1, 32'h8001_7FFF);
        chk("lhu_val", rf_wdata, 32'h00008001);
        do_load(3'd2, 32'h0000_2002, 5'd8, 1'b1, 0, 32'h0);
        do_load(3'd3, 32'h0000_2000, 5'd8, 1'b1, 0, 32'h0);
        do_load(3'd2, 32'h0000_3000, 5'd3, 1'b1, TIMEOUT, 32'h0);
        do_load(3'd2, 32'h0000_3000, 5'd3, 1'b1, TIMEOUT - 1, 32'h1357_9BDF);
        chk("ack_last_val", rf_wdata, 32'h1357_9BDF);

        // Stray ack while idle must not write
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        chk("stray_ack_we", 32'(rf_we), 32'd0);
        chk("stray_ack_busy", 32'(busy), 32'd0);

        // Reset in the middle of a load
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd4; in_wen = 1'b1;
        in_funct3 = 3'd2; in_result = 32'h0000_4000;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rd = 5'd0; exp_wdata = 32'h0;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
        step();
        dmem_ack = 1'b0;
        chk("mid_late_ack_we", 32'(rf_we), 32'd0);
        check_hold("mid");

        // Random mix of ALU ops and loads
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a = $urandom;
            f3 = 3'($urandom);
            if ($urandom_range(0, 2) == 0)
                do_alu(5'($urandom), 1'($urandom), a);
            else
                do_load(f3, a, 5'($urandom), 1'($urandom), int'($urandom_range(0, TIMEOUT + 1)),
                        $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I core. It sits directly upstream of the register file and drives its write port (we, rd, write data).
- Accepts one retired instruction at a time from the execute stage. ALU results pass straight through.
- Loads perform a variable-latency data-memory read with a req/ack handshake. Returned data is byte/halfword-aligned and sign- or zero-extended before the register write.
- Flags misaligned and timed-out loads.

Parameters:
- TIMEOUT, 16: maximum number of LOAD_WAIT cycles without dmem_ack before the load is abandoned.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept (high only in IDLE)
- in_rd  in  5  destination register
- in_wen  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_result  in  32  ALU result, or byte address for loads
- dmem_req  out  1  read request, held until ack or timeout
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_ack  in  1  read data valid this cycle
- dmem_rdata  in  32  read word
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file destination
- rf_wdata  out  32  register-file write data
- busy  out  1  state != IDLE
- load_err  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; rf_we=0, rf_rd=0, rf_wdata=0, dmem_req=0, dmem_addr=0, load_err=0, wait counter=0.
- Reset mid-load drops dmem_req on the next edge. A later dmem_ack for that load is ignored.
- Handshake: transfer occurs when in_valid & in_ready. in_ready = (state==IDLE). Inputs are captured on the transfer edge.
- State IDLE:
  - Non-load transfer: capture rd, wen, result; go to WRITE.
  - Load transfer, illegal: funct3 in {011,110,111}, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. Pulse load_err next cycle, perform no write, no dmem_req, stay IDLE.
  - Load transfer, legal: capture rd, wen, funct3, addr[1:0]; set dmem_req=1 and dmem_addr from the next cycle; clear counter; go to LOAD_WAIT.
- State LOAD_WAIT:
  - dmem_req and dmem_addr are held stable. Counter increments each cycle without ack.
  - On dmem_ack: select the byte (addr[1:0]) or halfword (addr[1]); sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the full word. Register the result into rf_wdata, drop dmem_req, go to WRITE.
  - Counter reaching TIMEOUT-1 with no ack: drop dmem_req, pulse load_err, no write, go to IDLE.
  - Ack on the same cycle as the timeout condition: ack wins; normal writeback, no error.
- State WRITE (exactly one cycle):
  - rf_we = wen & (rd != 0). rf_rd and rf_wdata are valid with rf_we.
  - Next state IDLE. rf_we is 0 in all other states.
- Latency:
  - ALU op: rf_we asserted 1 cycle after the transfer edge. Throughput is one instruction per 2 cycles.
  - Load: rf_we asserted 1 cycle after the ack edge.
- rf_rd and rf_wdata hold their last values when rf_we=0.
- dmem_ack outside LOAD_WAIT is ignored.

Test Plan:
- ALU op, rd=5, result=0xDEADBEEF, wen=1 → next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; in_ready low for that cycle only.
- ALU op with rd=0, wen=1 → rf_we stays 0; state returns to IDLE.
- LB at 0x1003; memory returns 0x80FF_1234 after 3 wait cycles → dmem_addr=0x1000 held 4 cycles; rf_wdata=0xFFFFFF80. The same access as LBU gives 0x00000080.
- LH at 0x2002, rdata=0x8001_7FFF → 0xFFFF8001. LHU → 0x00008001. LW at 0x2002 → load_err pulse, no dmem_req, no rf_we.
- Load with no ack → dmem_req high for exactly 16 cycles, then load_err pulse, no rf_we. A repeat run with ack on cycle 16 → normal write, no error.
- reset asserted during LOAD_WAIT → next edge dmem_req=0, state IDLE; an ack one cycle later produces no rf_we.
